// File: rtl/add_serial_seq_pkg.sv
// Shared types for the serial-adder operand sequencer: FSM states and the
// operand record that is queued between the input stream and the adder.
package add_serial_seq_pkg;

    localparam int SEQ_TAG_W = 4;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_HOLD    = 3'd3,
        ST_RELEASE = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [7:0]           a;
        logic [7:0]           b;
        logic [SEQ_TAG_W-1:0] tag;
    } op_rec_t;

    function automatic logic [SEQ_TAG_W-1:0] tag_inc(input logic [SEQ_TAG_W-1:0] t);
        return t + {{(SEQ_TAG_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/add_serial_seq_op_fifo.sv
// Synchronous operand FIFO; pointers carry one extra wrap bit so full and
// empty are told apart without a separate occupancy counter.
module op_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wptr_q;
    logic [AW:0]  rptr_q;
    logic [W-1:0] mem_q [DEPTH];
    logic         do_push_s;
    logic         do_pop_s;

    assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o   = (wptr_q == rptr_q);
    assign do_push_s = push_i && !full_o;
    assign do_pop_s  = pop_i && !empty_o;
    assign rdata_o   = mem_q[rptr_q[AW-1:0]];

    // Storage and pointer update; reset also clears stale entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push_s) begin
                mem_q[wptr_q[AW-1:0]] <= wdata_i;
                wptr_q                <= wptr_q + {{AW{1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rptr_q <= rptr_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/add_serial_seq.sv
// Operand sequencer for the 8-bit serial adder: queues (a, b) pairs, runs one
// add at a time through start/wait/release, and returns tagged sums.
module add_serial_seq
    import add_serial_seq_pkg::*;
#(
    parameter int DEPTH   = 2,
    parameter int ADD_LAT = 10,
    parameter int TAG_W   = SEQ_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_a,
    input  logic [7:0]       in_b,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_en,
    input  logic [7:0]       add_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_sum,
    output logic [TAG_W-1:0] res_tag
);

    localparam int LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(ADD_LAT - 1);

    seq_state_e       state_q;
    logic [LAT_W-1:0] lat_q;
    logic [TAG_W-1:0] tag_cnt_q;
    logic [TAG_W-1:0] tag_cnt_d;
    logic [TAG_W-1:0] cur_tag_q;
    logic [7:0]       add_a_q;
    logic [7:0]       add_b_q;
    logic             add_en_q;
    logic             res_valid_q;
    logic [7:0]       res_sum_q;
    logic [TAG_W-1:0] res_tag_q;

    op_rec_t          push_rec_s;
    op_rec_t          head_rec_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             accept_s;
    logic             pop_s;

    assign in_ready   = !fifo_full_s;
    assign accept_s   = in_valid && !fifo_full_s;
    assign pop_s      = (state_q == ST_IDLE) && !fifo_empty_s;
    assign push_rec_s = '{a: in_a, b: in_b, tag: tag_cnt_q};

    op_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(op_rec_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_valid),
        .pop_i   (pop_s),
        .wdata_i (push_rec_s),
        .rdata_o (head_rec_s),
        .full_o  (fifo_full_s),
        .empty_o (fifo_empty_s)
    );

    // Next sequence tag, advancing only on an accepted pair.
    always_comb begin
        tag_cnt_d = tag_cnt_q;
        if (accept_s) begin
            tag_cnt_d = tag_inc(tag_cnt_q);
        end else begin
            tag_cnt_d = tag_cnt_q;
        end
    end

    // Sequencer FSM; add_en is raised on entry to ISSUE and RELEASE so it is
    // high for exactly the cycle spent in those states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            lat_q       <= '0;
            tag_cnt_q   <= '0;
            cur_tag_q   <= '0;
            add_a_q     <= 8'd0;
            add_b_q     <= 8'd0;
            add_en_q    <= 1'b0;
            res_valid_q <= 1'b0;
            res_sum_q   <= 8'd0;
            res_tag_q   <= '0;
        end else begin
            tag_cnt_q <= tag_cnt_d;
            add_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        add_a_q   <= head_rec_s.a;
                        add_b_q   <= head_rec_s.b;
                        cur_tag_q <= head_rec_s.tag;
                        add_en_q  <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    lat_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (lat_q == LAT_LAST) begin
                        res_sum_q   <= add_out;
                        res_tag_q   <= cur_tag_q;
                        res_valid_q <= 1'b1;
                        state_q     <= ST_HOLD;
                    end else begin
                        lat_q <= lat_q + {{(LAT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_HOLD: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        add_en_q    <= 1'b1;
                        state_q     <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_en    = add_en_q;
    assign res_valid = res_valid_q;
    assign res_sum   = res_sum_q;
    assign res_tag   = res_tag_q;

endmodule

// File: tb/tb_add_serial_seq.sv
// Directed self-checking bench for add_serial_seq with a behavioural
// fixed-latency adder that outputs a wrong value until its latency elapses.
module tb_add_serial_seq;

    localparam int DEPTH   = 2;
    localparam int ADD_LAT = 10;
    localparam int TAG_W   = 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic             add_en;
    logic [7:0]       add_out;
    logic             res_valid;
    logic             res_ready;
    logic [7:0]       res_sum;
    logic [TAG_W-1:0] res_tag;

    int total = 0;
    int bad   = 0;
    int en_cnt;
    logic       m_busy;
    int         m_cnt;

    add_serial_seq #(.DEPTH(DEPTH), .ADD_LAT(ADD_LAT), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .add_a(add_a), .add_b(add_b), .add_en(add_en),
        .add_out(add_out), .res_valid(res_valid), .res_ready(res_ready),
        .res_sum(res_sum), .res_tag(res_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: first add_en starts, second releases; sum valid after ADD_LAT cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            add_out <= 8'd0;
        end else if (add_en) begin
            if (!m_busy) begin
                m_busy  <= 1'b1;
                m_cnt   <= 1;
                add_out <= ~(add_a + add_b);
            end else begin
                m_busy  <= 1'b0;
                add_out <= 8'd0;
            end
        end else if (m_busy && m_cnt < ADD_LAT) begin
            if (m_cnt == ADD_LAT - 1) add_out <= add_a + add_b;
            m_cnt <= m_cnt + 1;
        end
    end

    // Counts add_en pulses seen by the adder.
    always @(posedge clk or posedge rst) begin
        if (rst) en_cnt <= 0;
        else if (add_en) en_cnt <= en_cnt + 1;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_a = 8'd0; in_b = 8'd0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int w;
        w = 0;
        in_a = a; in_b = b; in_valid = 1'b1;
        while (!in_ready && w < 200) begin tick; w++; end
        if (w >= 200) begin
            bad++; total++;
            $display("FAIL push_timeout got in_ready=%0b exp=1", in_ready);
        end
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int limit, output int n);
        n = 0;
        while (!res_valid && n < limit) begin tick; n++; end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0; in_a = 8'd0; in_b = 8'd0;
        #3;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%0b exp=1", in_ready); end
        total++; if ({add_a, add_b} !== 16'd0) begin bad++; $display("FAIL rst_add_ab got=%h exp=0000", {add_a, add_b}); end
        total++; if ({add_en, res_valid} !== 2'b00) begin bad++; $display("FAIL rst_en_valid got=%b exp=00", {add_en, res_valid}); end
        total++; if ({res_sum, res_tag} !== 12'd0) begin bad++; $display("FAIL rst_res got=%h exp=000", {res_sum, res_tag}); end
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_single_op;
        int n;
        int e0;
        do_reset;
        res_ready = 1'b1;
        e0 = en_cnt;
        push(8'd3, 8'd5);
        wait_valid(40, n);
        total++; if (n !== ADD_LAT + 2) begin bad++; $display("FAIL single_latency got=%0d exp=%0d", n, ADD_LAT + 2); end
        total++; if (res_sum !== 8'd8) begin bad++; $display("FAIL single_sum got=%0d exp=8", res_sum); end
        total++; if (res_tag !== 4'd0) begin bad++; $display("FAIL single_tag got=%0d exp=0", res_tag); end
        total++; if ({add_a, add_b} !== {8'd3, 8'd5}) begin bad++; $display("FAIL single_add_ab got=%h exp=0305", {add_a, add_b}); end
        total++; if (en_cnt - e0 !== 1) begin bad++; $display("FAIL single_start_pulses got=%0d exp=1", en_cnt - e0); end
        tick;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL single_valid_drop got=%0b exp=0", res_valid); end
        tick;
        total++; if (en_cnt - e0 !== 2) begin bad++; $display("FAIL single_release_pulses got=%0d exp=2", en_cnt - e0); end
        total++; if (add_en !== 1'b0) begin bad++; $display("FAIL single_en_low got=%0b exp=0", add_en); end
    endtask

    task automatic test_overflow;
        int n;
        res_ready = 1'b1;
        push(8'd200, 8'd100);
        wait_valid(40, n);
        total++; if (res_sum !== 8'd44) begin bad++; $display("FAIL overflow_sum got=%0d exp=44", res_sum); end
        total++; if (res_tag !== 4'd1) begin bad++; $display("FAIL overflow_tag got=%0d exp=1", res_tag); end
        tick; tick;
    endtask

    task automatic test_backpressure;
        int n;
        logic [7:0] exp_sum [3];
        exp_sum = '{8'd30, 8'd70, 8'd110};
        do_reset;
        res_ready = 1'b0;
        push(8'd10, 8'd20);
        push(8'd30, 8'd40);
        push(8'd50, 8'd60);
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full got in_ready=%0b exp=0", in_ready); end
        wait_valid(40, n);
        for (int i = 0; i < 5; i++) begin
            tick;
            total++;
            if ({res_valid, res_sum, res_tag} !== {1'b1, 8'd30, 4'd0}) begin
                bad++; $display("FAIL bp_hold got v=%0b s=%0d t=%0d exp v=1 s=30 t=0", res_valid, res_sum, res_tag);
            end
        end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_still_full got=%0b exp=0", in_ready); end
        res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_valid(40, n);
            total++;
            if ({res_valid, res_sum, res_tag} !== {1'b1, exp_sum[i], 4'(i)}) begin
                bad++; $display("FAIL bp_drain%0d got v=%0b s=%0d t=%0d exp v=1 s=%0d t=%0d", i, res_valid, res_sum, res_tag, exp_sum[i], i);
            end
            tick;
        end
    endtask

    task automatic test_tag_wrap;
        int n;
        logic [7:0] a;
        logic [7:0] b;
        do_reset;
        res_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a = 8'(i); b = 8'(2 * i);
            push(a, b);
            wait_valid(40, n);
            total++;
            if ({res_valid, res_sum, res_tag} !== {1'b1, 8'(3 * i), 4'(i % 16)}) begin
                bad++; $display("FAIL tagwrap%0d got v=%0b s=%0d t=%0d exp v=1 s=%0d t=%0d", i, res_valid, res_sum, res_tag, 3 * i, i % 16);
            end
            tick;
        end
    endtask

    task automatic test_back_to_back;
        int n;
        do_reset;
        res_ready = 1'b1;
        push(8'd1, 8'd1);
        push(8'd2, 8'd2);
        wait_valid(40, n);
        total++; if ({res_sum, res_tag} !== {8'd2, 4'd0}) begin bad++; $display("FAIL b2b_first got s=%0d t=%0d exp s=2 t=0", res_sum, res_tag); end
        tick;
        wait_valid(40, n);
        total++; if (n + 1 !== ADD_LAT + 4) begin bad++; $display("FAIL b2b_interval got=%0d exp=%0d", n + 1, ADD_LAT + 4); end
        total++; if ({res_sum, res_tag} !== {8'd4, 4'd1}) begin bad++; $display("FAIL b2b_second got s=%0d t=%0d exp s=4 t=1", res_sum, res_tag); end
        tick;
    endtask

    task automatic test_reset_mid_wait;
        int n;
        do_reset;
        res_ready = 1'b1;
        push(8'd3, 8'd5);
        wait_valid(40, n);
        tick; tick;
        res_ready = 1'b0;
        push(8'd7, 8'd9);
        push(8'd11, 8'd13);
        tick; tick; tick;
        #2;
        rst = 1'b1;
        #1;
        total++; if ({in_ready, add_en, res_valid} !== 3'b100) begin bad++; $display("FAIL midrst_flags got=%b exp=100", {in_ready, add_en, res_valid}); end
        total++; if ({add_a, add_b} !== 16'd0) begin bad++; $display("FAIL midrst_add_ab got=%h exp=0000", {add_a, add_b}); end
        total++; if ({res_sum, res_tag} !== 12'd0) begin bad++; $display("FAIL midrst_res got=%h exp=000", {res_sum, res_tag}); end
        total++; if (dut.fifo_empty_s !== 1'b1) begin bad++; $display("FAIL midrst_fifo_empty got=%0b exp=1", dut.fifo_empty_s); end
        tick;
        rst = 1'b0;
        res_ready = 1'b1;
        push(8'd1, 8'd1);
        wait_valid(40, n);
        total++; if ({res_valid, res_sum, res_tag} !== {1'b1, 8'd2, 4'd0}) begin bad++; $display("FAIL midrst_after got v=%0b s=%0d t=%0d exp v=1 s=2 t=0", res_valid, res_sum, res_tag); end
        tick;
        wait_valid(30, n);
        total++; if (n !== 30) begin bad++; $display("FAIL midrst_no_stale got=%0d exp=30", n); end
    endtask

    task automatic test_simul_push_pop;
        int n;
        do_reset;
        res_ready = 1'b0;
        push(8'd1, 8'd2);
        wait_valid(40, n);
        push(8'd4, 8'd4);
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL spp_one_entry got in_ready=%0b exp=1", in_ready); end
        res_ready = 1'b1;
        tick;
        res_ready = 1'b0;
        tick;
        in_a = 8'd8; in_b = 8'd8; in_valid = 1'b1;
        tick;
        in_valid = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL spp_ready got=%0b exp=1", in_ready); end
        total++; if (dut.fifo_empty_s !== 1'b0) begin bad++; $display("FAIL spp_not_empty got=%0b exp=0", dut.fifo_empty_s); end
        total++; if ({add_a, add_b} !== {8'd4, 8'd4}) begin bad++; $display("FAIL spp_popped got=%h exp=0404", {add_a, add_b}); end
        res_ready = 1'b1;
        wait_valid(40, n);
        total++; if ({res_valid, res_sum, res_tag} !== {1'b1, 8'd8, 4'd1}) begin bad++; $display("FAIL spp_res1 got v=%0b s=%0d t=%0d exp v=1 s=8 t=1", res_valid, res_sum, res_tag); end
        tick;
        wait_valid(40, n);
        total++; if ({res_valid, res_sum, res_tag} !== {1'b1, 8'd16, 4'd2}) begin bad++; $display("FAIL spp_res2 got v=%0b s=%0d t=%0d exp v=1 s=16 t=2", res_valid, res_sum, res_tag); end
        tick;
    endtask

    initial begin
        test_reset;
        test_single_op;
        test_overflow;
        test_backpressure;
        test_tag_wrap;
        test_back_to_back;
        test_reset_mid_wait;
        test_simul_push_pop;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
